scc_mem_host: RTL and testbench
===============================

Name: scc_mem_host

Overview:
- Memory-side responder for the single-cycle core: one unified word RAM serves the core's instruction-fetch port and data load/store port.
- A host-side port loads programs before a run and dumps results after `halt_f`.
- A run-control FSM drives the core's reset, counts run cycles, enforces a watchdog and reports status.
- Sits between the core top level and the testbench/host.

Parameters:
- ADDR_W, 10, word-address width; RAM depth = 2**ADDR_W 32-bit words.
- MAX_CYCLES, 100000, watchdog limit on RUN cycles (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- core_rst  out  1  reset driven to the core
- mem_rd_en  in  1  core instruction-fetch enable (core memReadEn)
- pc  in  32  core programCounter, word address
- instr  out  32  fetched instruction
- dmem_rd  in  1  core data read strobe
- dmem_wr  in  1  core data write strobe
- dmem_addr  in  32  data word address
- dmem_wdata  in  32  store data
- dmem_rdata  out  32  load data
- halt_f  in  1  core halt
- host_go  in  1  start/restart run (1-cycle pulse)
- host_wr  in  1  host write strobe
- host_rd  in  1  host read strobe
- host_addr  in  ADDR_W  host word address
- host_wdata  in  32  host write data
- host_rdata  out  32  host read data
- host_rvalid  out  1  host_rdata valid pulse
- running  out  1  state==RUN
- halted  out  1  state==HALTED
- timeout  out  1  state==TIMEOUT
- cycle_count  out  32  RUN cycles of current/last run
- err_oob  out  1  sticky out-of-range core access

Behaviour:
- Clock and reset: single clock `clk`; `rst` is synchronous, active-high. The core's ports use the core's names (memReadEn, programCounter, data_memory_*) at the top level.
- Reset values: state=IDLE, core_rst=1, instr=0, host_rdata=0, host_rvalid=0, cycle_count=0, err_oob=0. RAM contents are not reset; `rst` mid-run returns to IDLE with RAM preserved.
- FSM states: IDLE, RUN, HALTED, TIMEOUT.
  - core_rst=1 in every state except RUN.
  - IDLE/HALTED/TIMEOUT --host_go--> RUN on the next edge. Entering RUN clears cycle_count and err_oob.
  - RUN --halt_f==1--> HALTED.
  - RUN --cycle_count==MAX_CYCLES-1 and halt_f==0--> TIMEOUT. If both conditions hold in the same cycle, halt wins.
  - host_go in RUN is ignored.
- Host port (IDLE/HALTED/TIMEOUT only):
  - host_wr writes mem[host_addr] at the edge.
  - host_rd gives host_rdata=mem[host_addr] registered, with host_rvalid high for exactly the next cycle.
  - host_wr and host_rd on the same address in the same cycle: rdata returns old data.
  - host_go together with host_wr: the write commits, then the FSM enters RUN.
  - In RUN, host_wr is dropped and host_rd produces no rvalid; host_rdata holds its value.
- Instruction port (RUN):
  - On an edge with mem_rd_en=1: instr <= mem[pc[ADDR_W-1:0]]. One-cycle latency.
  - instr holds its value when mem_rd_en=0 and outside RUN.
- Data port (RUN):
  - dmem_rdata = dmem_rd ? mem[dmem_addr[ADDR_W-1:0]] : 0, combinational.
  - dmem_wr writes at the edge.
  - Read and write to the same address in one cycle: rdata shows old contents.
  - Writes in the cycle where halt_f rises still commit.
  - Outside RUN, dmem_rdata=0 and writes are dropped.
- Out-of-range access: pc[31:ADDR_W]!=0 with mem_rd_en, or dmem_addr[31:ADDR_W]!=0 with dmem_rd/dmem_wr:
  - reads return 0 (instr or dmem_rdata);
  - writes are dropped;
  - err_oob sets at the edge and stays set until rst or the next host_go.
- Cycle counter: cycle_count increments every RUN cycle including the halting cycle, saturates at 2^32-1, and freezes outside RUN.
- Write-port priority: the core port has the only write access in RUN; the host has it otherwise. There is never a collision.

Decomposition:
- Package scc_mem_pkg: state encoding (IDLE=2'd0, RUN=2'd1, HALTED=2'd2, TIMEOUT=2'd3) and default ADDR_W/MAX_CYCLES constants.
- One sub-module, scc_word_ram:
  - one write port (muxed core/host by state);
  - one synchronous read port (instr/host, muxed by state);
  - one asynchronous read port (data).
- FSM, counter, range checks and muxing live in scc_mem_host.

Test Plan:
- Load: host_wr addr 0..3 = 0x11,0x22,0x33,0x44, then host_rd addr 2 -> host_rvalid 1 cycle later with host_rdata=0x33; core_rst=1 throughout.
- Run/fetch: host_go, then mem_rd_en=1, pc=1 -> instr=0x22 one cycle later; core_rst=0, running=1, cycle_count increments 1,2,3.
- Store/load: in RUN, dmem_wr addr 5 data 0xDEADBEEF, next cycle dmem_rd addr 5 -> dmem_rdata=0xDEADBEEF the same cycle. Same-cycle rd+wr to addr 6 (old 0) -> rdata=0.
- Halt: halt_f=1 with dmem_wr addr 7 = 0x5 in the same cycle -> HALTED, core_rst=1, cycle_count frozen; host_rd 7 -> 0x5.
- Watchdog: MAX_CYCLES=8, never halt -> timeout=1 after exactly 8 RUN cycles, cycle_count=8. halt_f on the 8th cycle -> halted instead.
- OOB/reset: dmem_wr addr 0x400 (ADDR_W=10) -> err_oob=1, mem[0] unchanged. rst mid-run -> IDLE, err_oob=0, RAM contents intact on host_rd.

Source files
------------

// File: rtl/scc_mem_pkg.sv
// Shared definitions for the single-cycle-core memory host: run-control state
// encoding and default geometry/watchdog constants.
package scc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } run_state_e;

  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_MAX_CYCLES = 100000;

endpackage

// File: rtl/scc_word_ram.sv
// Unified 32-bit word RAM: one write port, one registered read port and one
// combinational read port. Contents are never reset.
module scc_word_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata,
  input  logic [ADDR_W-1:0] araddr,
  output logic [31:0]       ardata
);

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rdata_q;

  // Read and write in one block so a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata  = rdata_q;
  assign ardata = mem[araddr];

endmodule

// File: rtl/scc_mem_host.sv
// Memory-side responder for the single-cycle core: shared RAM for fetch and
// data, host load/dump port, and run-control FSM with cycle counter/watchdog.
module scc_mem_host
  import scc_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  output logic              core_rst,
  input  logic              mem_rd_en,
  input  logic [31:0]       pc,
  output logic [31:0]       instr,
  input  logic              dmem_rd,
  input  logic              dmem_wr,
  input  logic [31:0]       dmem_addr,
  input  logic [31:0]       dmem_wdata,
  output logic [31:0]       dmem_rdata,
  input  logic              halt_f,
  input  logic              host_go,
  input  logic              host_wr,
  input  logic              host_rd,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  output logic [31:0]       host_rdata,
  output logic              host_rvalid,
  output logic              running,
  output logic              halted,
  output logic              timeout,
  output logic [31:0]       cycle_count,
  output logic              err_oob
);

  localparam logic [31:0] LAST_CYCLE = 32'(MAX_CYCLES - 1);

  run_state_e  state_q, state_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic        err_oob_q, err_oob_d;
  logic        host_rvalid_q, host_rvalid_d;
  logic        instr_fresh_q, instr_fresh_d;
  logic [31:0] instr_hold_q, instr_hold_d;
  logic        host_fresh_q, host_fresh_d;
  logic [31:0] host_hold_q, host_hold_d;

  logic              in_run, start;
  logic              pc_oob, d_oob;
  logic              fetch_ok, fetch_oob, host_rd_ok;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [31:0]       ram_wdata, ram_rdata, ram_ardata;

  assign in_run     = (state_q == ST_RUN);
  assign start      = !in_run && host_go;
  assign pc_oob     = (pc[31:ADDR_W] != '0);
  assign d_oob      = (dmem_addr[31:ADDR_W] != '0);
  assign fetch_ok   = in_run && mem_rd_en && !pc_oob;
  assign fetch_oob  = in_run && mem_rd_en && pc_oob;
  assign host_rd_ok = !in_run && host_rd;

  // Port muxing: the core owns the RAM in RUN, the host owns it otherwise.
  always_comb begin
    ram_we    = host_wr;
    ram_waddr = host_addr;
    ram_wdata = host_wdata;
    ram_re    = host_rd_ok;
    ram_raddr = host_addr;
    if (in_run) begin
      ram_we    = dmem_wr && !d_oob;
      ram_waddr = dmem_addr[ADDR_W-1:0];
      ram_wdata = dmem_wdata;
      ram_re    = fetch_ok;
      ram_raddr = pc[ADDR_W-1:0];
    end
  end

  scc_word_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk    (clk),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata),
    .re     (ram_re),
    .raddr  (ram_raddr),
    .rdata  (ram_rdata),
    .araddr (dmem_addr[ADDR_W-1:0]),
    .ardata (ram_ardata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cycle_count_q <= '0;
      err_oob_q     <= 1'b0;
      host_rvalid_q <= 1'b0;
      instr_fresh_q <= 1'b0;
      instr_hold_q  <= '0;
      host_fresh_q  <= 1'b0;
      host_hold_q   <= '0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      err_oob_q     <= err_oob_d;
      host_rvalid_q <= host_rvalid_d;
      instr_fresh_q <= instr_fresh_d;
      instr_hold_q  <= instr_hold_d;
      host_fresh_q  <= host_fresh_d;
      host_hold_q   <= host_hold_d;
    end
  end

  // Halt takes priority over the watchdog when both land in one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (halt_f)                           state_d = ST_HALTED;
        else if (cycle_count_q == LAST_CYCLE) state_d = ST_TIMEOUT;
      end
      default: begin
        if (host_go) state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    core_rst = !in_run;
    running  = in_run;
    halted   = (state_q == ST_HALTED);
    timeout  = (state_q == ST_TIMEOUT);
  end

  always_comb begin
    cycle_count_d = cycle_count_q;
    if (start)                                  cycle_count_d = '0;
    else if (in_run && cycle_count_q != '1)     cycle_count_d = cycle_count_q + 32'd1;

    err_oob_d = err_oob_q;
    if (start) err_oob_d = 1'b0;
    else if (in_run && ((mem_rd_en && pc_oob) || ((dmem_rd || dmem_wr) && d_oob)))
      err_oob_d = 1'b1;

    host_rvalid_d = host_rd_ok;
  end

  // The shared read register only reflects the latest access for one cycle;
  // each consumer keeps its own copy so the other port cannot disturb it.
  always_comb begin
    instr_fresh_d = fetch_ok;
    instr_hold_d  = fetch_oob ? 32'd0 : instr;
    host_fresh_d  = host_rd_ok;
    host_hold_d   = host_rdata;
  end

  always_comb begin
    instr       = instr_fresh_q ? ram_rdata : instr_hold_q;
    host_rdata  = host_fresh_q ? ram_rdata : host_hold_q;
    host_rvalid = host_rvalid_q;
    cycle_count = cycle_count_q;
    err_oob     = err_oob_q;
    dmem_rdata  = (in_run && dmem_rd && !d_oob) ? ram_ardata : 32'd0;
  end

endmodule

// File: tb/tb_scc_mem_host.sv
// Directed bench for scc_mem_host: load, fetch, store/load, halt, watchdog,
// out-of-range access and mid-run reset.
module tb_scc_mem_host;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst, core_rst, mem_rd_en, dmem_rd, dmem_wr, halt_f;
  logic              host_go, host_wr, host_rd, host_rvalid;
  logic              running, halted, timeout, err_oob;
  logic [31:0]       pc, instr, dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0]       host_wdata, host_rdata, cycle_count;
  logic [ADDR_W-1:0] host_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scc_mem_host #(.ADDR_W(ADDR_W), .MAX_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .core_rst(core_rst),
    .mem_rd_en(mem_rd_en), .pc(pc), .instr(instr),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .halt_f(halt_f), .host_go(host_go), .host_wr(host_wr), .host_rd(host_rd),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .running(running), .halted(halted),
    .timeout(timeout), .cycle_count(cycle_count), .err_oob(err_oob)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    host_wr = 1'b1; host_addr = a; host_wdata = d;
    step();
    host_wr = 1'b0;
  endtask

  task automatic host_read_chk(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    host_rd = 1'b1; host_addr = a;
    step();
    host_rd = 1'b0;
    check_eq({tag, "_rvalid"}, {31'd0, host_rvalid}, 32'd1);
    check_eq({tag, "_rdata"}, host_rdata, exp);
  endtask

  task automatic go();
    host_go = 1'b1;
    step();
    host_go = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_rd_en = 0; pc = 0; dmem_rd = 0; dmem_wr = 0;
    dmem_addr = 0; dmem_wdata = 0; halt_f = 0; host_go = 0;
    host_wr = 0; host_rd = 0; host_addr = 0; host_wdata = 0;
    step(); step();
    rst = 1'b0;
    #1;
    check_eq("rst_core_rst", {31'd0, core_rst}, 32'd1);
    check_eq("rst_running", {31'd0, running}, 32'd0);
    check_eq("rst_instr", instr, 32'd0);
    check_eq("rst_host_rdata", host_rdata, 32'd0);
    check_eq("rst_rvalid", {31'd0, host_rvalid}, 32'd0);
    check_eq("rst_cycles", cycle_count, 32'd0);
    check_eq("rst_err_oob", {31'd0, err_oob}, 32'd0);

    // Program load
    host_write(0, 32'h11); host_write(1, 32'h22);
    host_write(2, 32'h33); host_write(3, 32'h44);
    host_write(6, 32'h0);  host_write(7, 32'h0);
    host_read_chk("load_rd2", 2, 32'h33);
    step();
    check_eq("rvalid_one_cycle", {31'd0, host_rvalid}, 32'd0);
    check_eq("rdata_hold", host_rdata, 32'h33);
    check_eq("load_core_rst", {31'd0, core_rst}, 32'd1);

    // Run and fetch
    go();
    check_eq("run_running", {31'd0, running}, 32'd1);
    check_eq("run_core_rst", {31'd0, core_rst}, 32'd0);
    check_eq("run_cyc0", cycle_count, 32'd0);
    mem_rd_en = 1; pc = 1;
    step();
    mem_rd_en = 0;
    check_eq("fetch_pc1", instr, 32'h22);
    check_eq("run_cyc1", cycle_count, 32'd1);
    host_rd = 1; host_addr = 3; host_wr = 1; host_wdata = 32'hBAD;
    step();
    host_rd = 0; host_wr = 0;
    check_eq("instr_hold", instr, 32'h22);
    check_eq("run_no_rvalid", {31'd0, host_rvalid}, 32'd0);
    check_eq("run_cyc2", cycle_count, 32'd2);
    step();
    check_eq("run_cyc3", cycle_count, 32'd3);

    // Store then load, and same-cycle read/write
    dmem_wr = 1; dmem_addr = 5; dmem_wdata = 32'hDEADBEEF;
    step();
    dmem_wr = 0; dmem_rd = 1; #1;
    check_eq("load_addr5", dmem_rdata, 32'hDEADBEEF);
    dmem_wr = 1; dmem_addr = 6; dmem_wdata = 32'h77; #1;
    check_eq("rw_same_old", dmem_rdata, 32'h0);
    step();
    dmem_wr = 0; #1;
    check_eq("rw_same_new", dmem_rdata, 32'h77);
    dmem_rd = 0;

    // Halt with a store in the same cycle
    halt_f = 1; dmem_wr = 1; dmem_addr = 7; dmem_wdata = 32'h5;
    step();
    halt_f = 0; dmem_wr = 0;
    check_eq("halt_halted", {31'd0, halted}, 32'd1);
    check_eq("halt_core_rst", {31'd0, core_rst}, 32'd1);
    check_eq("halt_cycles", cycle_count, 32'd6);
    dmem_rd = 1; dmem_addr = 5; #1;
    check_eq("idle_dmem_rdata", dmem_rdata, 32'd0);
    dmem_rd = 0;
    step();
    check_eq("halt_frozen", cycle_count, 32'd6);
    host_read_chk("halt_rd7", 7, 32'h5);
    host_read_chk("run_wr_dropped", 3, 32'h44);

    // Watchdog timeout
    go();
    for (int i = 0; i < 7; i++) step();
    check_eq("wd_not_yet", {31'd0, timeout}, 32'd0);
    check_eq("wd_cyc7", cycle_count, 32'd7);
    step();
    check_eq("wd_timeout", {31'd0, timeout}, 32'd1);
    check_eq("wd_cyc8", cycle_count, 32'd8);
    step();
    check_eq("wd_frozen", cycle_count, 32'd8);

    // Halt on the last allowed cycle wins over timeout
    go();
    for (int i = 0; i < 7; i++) step();
    halt_f = 1;
    step();
    halt_f = 0;
    check_eq("wd_halt_halted", {31'd0, halted}, 32'd1);
    check_eq("wd_halt_timeout", {31'd0, timeout}, 32'd0);
    check_eq("wd_halt_cyc", cycle_count, 32'd8);

    // Out-of-range accesses, then reset mid-run
    go();
    mem_rd_en = 1; pc = 0;
    step();
    check_eq("fetch_pc0", instr, 32'h11);
    check_eq("oob_clear", {31'd0, err_oob}, 32'd0);
    pc = 32'h400; dmem_rd = 1; dmem_addr = 32'h400; #1;
    check_eq("oob_dmem_rdata", dmem_rdata, 32'd0);
    dmem_rd = 0; dmem_wr = 1; dmem_wdata = 32'hBAD;
    step();
    mem_rd_en = 0; dmem_wr = 0;
    check_eq("oob_instr", instr, 32'd0);
    check_eq("oob_sticky", {31'd0, err_oob}, 32'd1);
    step();
    check_eq("oob_sticky2", {31'd0, err_oob}, 32'd1);
    rst = 1;
    step();
    rst = 0;
    check_eq("mid_rst_running", {31'd0, running}, 32'd0);
    check_eq("mid_rst_core_rst", {31'd0, core_rst}, 32'd1);
    check_eq("mid_rst_err_oob", {31'd0, err_oob}, 32'd0);
    check_eq("mid_rst_cycles", cycle_count, 32'd0);
    host_read_chk("oob_mem0", 0, 32'h11);
    host_read_chk("ram_kept5", 5, 32'hDEADBEEF);

    // Write then start in the same cycle
    host_go = 1; host_wr = 1; host_addr = 9; host_wdata = 32'h99;
    step();
    host_go = 0; host_wr = 0;
    check_eq("go_wr_running", {31'd0, running}, 32'd1);
    mem_rd_en = 1; pc = 9;
    step();
    mem_rd_en = 0;
    check_eq("go_wr_commit", instr, 32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
